// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns the PS/2 receiver byte stream into make/break events.
// It handles the E0 (extended), F0 (break) and E1 (pause) prefixes, keeps an
// 8-bit held-key vector for arcade controls, and queues every event in a small
// FIFO with a valid/ready pop interface.
// Optional feature: define PS2_DEC_TIMEOUT_EN to abandon a partial prefix
// sequence after TIMEOUT_CYCLES clocks with no new byte.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] code,
  output logic [7:0] keys,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  state_t     state;
  logic [2:0] skip_cnt;
  logic       emit, e_brk, e_ext, tmo;
  logic [7:0] e_code;

  // Bit of the held-key vector driven by a scan code; pause is never mapped
  // here because it is toggled by the E1 sequence instead.
  function automatic logic [7:0] keymask(input logic [7:0] c);
    case (c)
      8'h1D, 8'h75: keymask = 8'h01;
      8'h1B, 8'h72: keymask = 8'h02;
      8'h1C, 8'h6B: keymask = 8'h04;
      8'h23, 8'h74: keymask = 8'h08;
      8'h29:        keymask = 8'h10;
      8'h5A:        keymask = 8'h20;
      8'h16:        keymask = 8'h40;
      default:      keymask = 8'h00;
    endcase
  endfunction

  // Decide whether this byte completes an event, and what kind.
  always_comb begin
    emit  = 1'b0;
    e_brk = 1'b0;
    e_ext = 1'b0;
    if (valid) begin
      unique case (state)
        IDLE:    emit = (code != 8'hE0) && (code != 8'hF0) && (code != 8'hE1);
        EXT:     begin emit = (code != 8'hF0); e_ext = 1'b1; end
        BRK:     begin emit = 1'b1; e_brk = 1'b1; end
        EXT_BRK: begin emit = 1'b1; e_brk = 1'b1; e_ext = 1'b1; end
        SKIP:    emit = (skip_cnt == 3'd1);
        default: emit = 1'b0;
      endcase
    end
  end

  // The whole pause sequence collapses into a single E1 event.
  assign e_code = (state == SKIP) ? 8'hE1 : code;

`ifdef PS2_DEC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Idle-time counter for a pending prefix; any byte restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          tmo_cnt <= '0;
    else if (valid || state == IDLE)  tmo_cnt <= '0;
    else                              tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive edge without a byte.
  assign tmo = !valid && (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo        = 1'b0;
`endif

  // Prefix FSM and held-key vector; keys update even if the event is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      skip_cnt <= 3'd0;
      keys     <= 8'h00;
    end else begin
      if (tmo) begin
        state <= IDLE;
      end else if (valid) begin
        unique case (state)
          IDLE: begin
            if (code == 8'hE0)      state <= EXT;
            else if (code == 8'hF0) state <= BRK;
            else if (code == 8'hE1) begin
              state    <= SKIP;
              skip_cnt <= 3'd7;
            end
          end
          EXT:          state <= (code == 8'hF0) ? EXT_BRK : IDLE;
          BRK, EXT_BRK: state <= IDLE;
          SKIP: begin
            if (skip_cnt == 3'd1) state <= IDLE;
            skip_cnt <= skip_cnt - 3'd1;
          end
          default:      state <= IDLE;
        endcase
      end
      if (emit) begin
        if (state == SKIP) keys[7] <= ~keys[7];
        else if (e_brk)    keys    <= keys & ~keymask(code);
        else               keys    <= keys | keymask(code);
      end
    end
  end

  // ---------------- event FIFO ----------------
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, push, pop;
  logic [9:0]    head;

  assign full = (count == (AW+1)'(FIFO_DEPTH));
  assign pop  = ev_valid & ev_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign push = emit & (~full | pop);

  // Storage, pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {e_brk, e_ext, e_code};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (emit && !push) overflow <= 1'b1;
    end
  end

  // Head fields come straight from registers and read as zero when empty.
  assign ev_valid = (count != '0);
  assign head     = ev_valid ? mem[rd_ptr] : 10'd0;
  assign ev_break = head[9];
  assign ev_ext   = head[8];
  assign ev_code  = head[7:0];

endmodule
